// File: rtl/spi_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : spi_pkg                                                 |
// | Description : Shared SPI constants: mode encodings {CPOL,CPHA}, the   |
// |               default word width / FIFO depth, and a helper that      |
// |               selects the sampling edge for a given mode.             |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
package spi_pkg;

  // Mode encodings as {CPOL, CPHA}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;

  // Modes 0 and 3 capture on the rising SCK edge, modes 1 and 2 on the falling edge.
  function automatic logic sample_on_rise(input logic [1:0] mode);
    return ~(mode[1] ^ mode[0]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_rx_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : spi_rx_fifo                                             |
// | Description : Show-ahead synchronous FIFO with full/empty/count.      |
// |               Push is refused only when full and not popping in the   |
// |               same cycle; head reads back 0 while empty.              |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
module spi_rx_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic [DW-1:0]            head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_pop;
  logic          w_push;

  assign full   = (r_count == FULL_CNT);
  assign empty  = (r_count == '0);
  assign count  = r_count;

  // A pop frees the slot a same-cycle push needs, so a full FIFO can still accept.
  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);

  assign head_data = empty ? '0 : r_mem[r_rd_ptr];

  // Storage array; written at the tail, no reset needed since head is gated when empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_slave_rx_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : spi_slave_rx_fifo                                       |
// | Description : Receive-only SPI slave. SCK/SSEL/MOSI are synchronised  |
// |               to clk, words are shifted MSB first and pushed into a   |
// |               show-ahead FIFO. Sticky OVERFLOW on dropped words,      |
// |               one-cycle FRAME_ERR on a truncated word.                |
// |               Optional: define SPI_RX_FRAME_TAG_EN to store a         |
// |               start-of-frame tag per entry, presented on SOF.         |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
module spi_slave_rx_fifo
  import spi_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CPOL  = 0,
  parameter int CPHA  = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     SCK,
  input  logic                     SSEL,
  input  logic                     MOSI,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         DATA,
  output logic                     VALID,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     OVERFLOW,
  input  logic                     ovf_clr,
  output logic                     FRAME_ERR,
  output logic                     SOF
);

  localparam int   CW          = $clog2(WIDTH);
  localparam logic SCK_IDLE    = (CPOL != 0);
  localparam logic SAMPLE_RISE = sample_on_rise({(CPOL != 0), (CPHA != 0)});
`ifdef SPI_RX_FRAME_TAG_EN
  localparam int   FW          = WIDTH + 1;
`else
  localparam int   FW          = WIDTH;
`endif

  logic [2:0]       r_sck_sync;
  logic [2:0]       r_ssel_sync;
  logic [1:0]       r_mosi_sync;
  logic [1:0]       r_flush;
  logic             r_armed;
  logic [CW-1:0]    r_bit_cnt;
  logic [WIDTH-2:0] r_shift;
  logic             r_frame_err;
  logic             r_ovf;

  logic             w_sck_rise;
  logic             w_sck_fall;
  logic             w_ssel_assert;
  logic             w_ssel_deassert;
  logic             w_ssel_idle;
  logic             w_ready;
  logic             w_sample;
  logic             w_last;
  logic             w_push;
  logic             w_drop;
  logic [FW-1:0]    w_push_data;
  logic [FW-1:0]    w_head;
  logic             w_full;
  logic             w_empty;

  // Synchronisers: shift the asynchronous pins in, oldest stage at the top bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sck_sync  <= {3{SCK_IDLE}};
      r_ssel_sync <= 3'b111;
      r_mosi_sync <= 2'b00;
    end else begin
      r_sck_sync  <= {r_sck_sync[1:0], SCK};
      r_ssel_sync <= {r_ssel_sync[1:0], SSEL};
      r_mosi_sync <= {r_mosi_sync[0], MOSI};
    end
  end

  assign w_sck_rise      =  r_sck_sync[1]  & ~r_sck_sync[2];
  assign w_sck_fall      = ~r_sck_sync[1]  &  r_sck_sync[2];
  assign w_ssel_assert   = ~r_ssel_sync[1] &  r_ssel_sync[2];
  assign w_ssel_deassert =  r_ssel_sync[1] & ~r_ssel_sync[2];
  assign w_ssel_idle     =  r_ssel_sync[1];

  // Hold off edge detection until the synchronisers carry real pin values, so the
  // reset value of SSEL cannot look like an assertion edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flush <= 2'd0;
    end else if (!w_ready) begin
      r_flush <= r_flush + 1'b1;
    end
  end

  assign w_ready  = &r_flush;
  assign w_sample = (SAMPLE_RISE ? w_sck_rise : w_sck_fall) & r_armed & ~w_ssel_idle;
  assign w_last   = (r_bit_cnt == CW'(WIDTH - 1));
  assign w_push   = w_sample & w_last;

  // Framer: arm on a genuine SSEL assertion edge, count/shift sample edges,
  // flag a truncated word when SSEL leaves with bits pending.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_armed     <= 1'b0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      if (!w_ready) begin
        r_armed   <= 1'b0;
        r_bit_cnt <= '0;
      end else if (w_ssel_idle) begin
        r_armed     <= 1'b0;
        r_bit_cnt   <= '0;
        r_frame_err <= w_ssel_deassert & (r_bit_cnt != '0);
      end else begin
        if (w_ssel_assert) begin
          r_armed <= 1'b1;
        end
        if (w_sample) begin
          r_shift   <= {r_shift[WIDTH-3:0], r_mosi_sync[1]};
          r_bit_cnt <= w_last ? '0 : r_bit_cnt + 1'b1;
        end
      end
    end
  end

`ifdef SPI_RX_FRAME_TAG_EN
  logic r_first;

  // Start-of-frame tag: set by each SSEL assertion, consumed by the first completed word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_first <= 1'b0;
    end else if (w_ready && w_ssel_assert) begin
      r_first <= 1'b1;
    end else if (w_push) begin
      r_first <= 1'b0;
    end
  end

  assign w_push_data = {r_first, r_shift, r_mosi_sync[1]};
  assign SOF         = w_head[WIDTH];
`else
  assign w_push_data = {r_shift, r_mosi_sync[1]};
  assign SOF         = 1'b0;
`endif

  spi_rx_fifo #(
    .DW    (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (rd_en),
    .head_data (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .count     (COUNT)
  );

  // A word is lost only when full and no pop makes room in the same cycle.
  assign w_drop = w_push & w_full & ~(rd_en & ~w_empty);

  // Sticky overflow flag; a new drop wins over a simultaneous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign DATA      = w_head[WIDTH-1:0];
  assign VALID     = ~w_empty;
  assign OVERFLOW  = r_ovf;
  assign FRAME_ERR = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_rx_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : tb_spi_slave_rx_fifo                                    |
// | Description : Self-checking bench for spi_slave_rx_fifo. Instance 0   |
// |               is mode 0 / 8 bit / depth 4, instance 1 is mode 3 /     |
// |               12 bit / depth 4. Single-word frames come from a        |
// |               vector table; multi-cycle corners are hand sequences.   |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
module tb_spi_slave_rx_fifo;

`ifdef SPI_RX_FRAME_TAG_EN
  localparam logic TAG = 1'b1;
`else
  localparam logic TAG = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;

  logic        sck0, ssel0, mosi0, rd0, clr0;
  logic [7:0]  data0;
  logic [2:0]  count0;
  logic        valid0, ovf0, fe0, sof0;

  logic        sck1, ssel1, mosi1, rd1, clr1;
  logic [11:0] data1;
  logic [2:0]  count1;
  logic        valid1, ovf1, fe1, sof1;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  spi_slave_rx_fifo #(.WIDTH(8), .DEPTH(4), .CPOL(0), .CPHA(0)) dut0 (
    .clk(clk), .reset(rst_n), .SCK(sck0), .SSEL(ssel0), .MOSI(mosi0),
    .rd_en(rd0), .DATA(data0), .VALID(valid0), .COUNT(count0),
    .OVERFLOW(ovf0), .ovf_clr(clr0), .FRAME_ERR(fe0), .SOF(sof0)
  );

  spi_slave_rx_fifo #(.WIDTH(12), .DEPTH(4), .CPOL(1), .CPHA(1)) dut1 (
    .clk(clk), .reset(rst_n), .SCK(sck1), .SSEL(ssel1), .MOSI(mosi1),
    .rd_en(rd1), .DATA(data1), .VALID(valid1), .COUNT(count1),
    .OVERFLOW(ovf1), .ovf_clr(clr1), .FRAME_ERR(fe1), .SOF(sof1)
  );

  typedef struct {
    int          inst;
    logic [31:0] word;
    logic [31:0] exp_data;
    logic        exp_sof;
  } vec_t;

  localparam int NV = 9;
  vec_t tbl [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Mode-0 master: data set while SCK low, slave samples on the rising edge.
  task automatic m0_bits(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      mosi0 = w[i];
      wait_clks(4);
      sck0 = 1'b1;
      wait_clks(4);
      sck0 = 1'b0;
    end
  endtask

  task automatic m0_open();
    ssel0 = 1'b0;
    wait_clks(4);
  endtask

  task automatic m0_close();
    wait_clks(4);
    ssel0 = 1'b1;
    wait_clks(8);
  endtask

  task automatic pop0();
    rd0 = 1'b1;
    wait_clks(1);
    rd0 = 1'b0;
  endtask

  // Mode-3 master: launch on the falling (leading) edge, slave samples on rising.
  task automatic m3_bits(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sck1  = 1'b0;
      mosi1 = w[i];
      wait_clks(4);
      sck1  = 1'b1;
      wait_clks(4);
    end
  endtask

  task automatic m3_frame(input logic [31:0] w);
    ssel1 = 1'b0;
    wait_clks(4);
    m3_bits(w, 12);
    wait_clks(4);
    ssel1 = 1'b1;
    wait_clks(8);
  endtask

  task automatic pop1();
    rd1 = 1'b1;
    wait_clks(1);
    rd1 = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fe_cycles;

    tbl[0] = '{0, 32'h0A5, 32'h0A5, TAG};
    tbl[1] = '{0, 32'h000, 32'h000, TAG};
    tbl[2] = '{0, 32'h0FF, 32'h0FF, TAG};
    tbl[3] = '{0, 32'h081, 32'h081, TAG};
    tbl[4] = '{0, 32'h096, 32'h096, TAG};
    tbl[5] = '{1, 32'hABC, 32'hABC, TAG};
    tbl[6] = '{1, 32'h001, 32'h001, TAG};
    tbl[7] = '{1, 32'hFFF, 32'hFFF, TAG};
    tbl[8] = '{1, 32'h800, 32'h800, TAG};

    rst_n = 1'b0;
    sck0 = 1'b0; ssel0 = 1'b1; mosi0 = 1'b0; rd0 = 1'b0; clr0 = 1'b0;
    sck1 = 1'b1; ssel1 = 1'b1; mosi1 = 1'b0; rd1 = 1'b0; clr1 = 1'b0;
    wait_clks(3);

    // Reset state
    check("reset valid0", 32'(valid0), 32'd0);
    check("reset count0", 32'(count0), 32'd0);
    check("reset data0",  32'(data0),  32'd0);
    check("reset ovf0",   32'(ovf0),   32'd0);
    check("reset fe0",    32'(fe0),    32'd0);
    check("reset sof0",   32'(sof0),   32'd0);
    check("reset valid1", 32'(valid1), 32'd0);
    check("reset count1", 32'(count1), 32'd0);
    rst_n = 1'b1;
    wait_clks(8);

    // Table: single-word frames, read back and popped
    for (int k = 0; k < NV; k++) begin
      if (tbl[k].inst == 0) begin
        m0_open();
        m0_bits(tbl[k].word, 8);
        m0_close();
        check($sformatf("tbl[%0d] data",  k), 32'(data0),  tbl[k].exp_data);
        check($sformatf("tbl[%0d] valid", k), 32'(valid0), 32'd1);
        check($sformatf("tbl[%0d] count", k), 32'(count0), 32'd1);
        check($sformatf("tbl[%0d] sof",   k), 32'(sof0),   32'(tbl[k].exp_sof));
        pop0();
        check($sformatf("tbl[%0d] empty valid", k), 32'(valid0), 32'd0);
        check($sformatf("tbl[%0d] empty data",  k), 32'(data0),  32'd0);
      end else begin
        m3_frame(tbl[k].word);
        check($sformatf("tbl[%0d] data",  k), 32'(data1),  tbl[k].exp_data);
        check($sformatf("tbl[%0d] valid", k), 32'(valid1), 32'd1);
        check($sformatf("tbl[%0d] count", k), 32'(count1), 32'd1);
        check($sformatf("tbl[%0d] sof",   k), 32'(sof1),   32'(tbl[k].exp_sof));
        pop1();
        check($sformatf("tbl[%0d] empty valid", k), 32'(valid1), 32'd0);
        check($sformatf("tbl[%0d] empty data",  k), 32'(data1),  32'd0);
      end
    end

    // Two words in one frame: SOF only on the first, COUNT 2 -> 1 -> 0
    m0_open();
    m0_bits(32'hA5, 8);
    m0_bits(32'h3C, 8);
    m0_close();
    check("pair count2", 32'(count0), 32'd2);
    check("pair data1",  32'(data0),  32'hA5);
    check("pair sof1",   32'(sof0),   32'(TAG));
    pop0();
    check("pair count1", 32'(count0), 32'd1);
    check("pair data2",  32'(data0),  32'h3C);
    check("pair sof2",   32'(sof0),   32'd0);
    pop0();
    check("pair count0", 32'(count0), 32'd0);
    check("pair valid0", 32'(valid0), 32'd0);

    // Mode-3 slave driven with data launched on its sampling edge: each sample
    // sees the previous bit, so 0xABC arrives as 0xABC >> 1 = 0x55E.
    sck1  = 1'b0;
    mosi1 = 1'b0;
    wait_clks(8);
    ssel1 = 1'b0;
    wait_clks(4);
    for (int i = 11; i >= 0; i--) begin
      sck1 = 1'b1;
      wait_clks(1);
      mosi1 = 12'hABC >> i;
      wait_clks(3);
      sck1 = 1'b0;
      wait_clks(4);
    end
    wait_clks(4);
    ssel1 = 1'b1;
    wait_clks(8);
    sck1 = 1'b1;
    wait_clks(8);
    check("phase mismatch valid", 32'(valid1), 32'd1);
    check("phase mismatch data",  32'(data1),  32'h55E);
    pop1();

    // Overflow: five words into depth 4, no reads
    m0_open();
    for (int i = 1; i <= 5; i++) m0_bits(32'(i), 8);
    m0_close();
    check("ovf count",    32'(count0), 32'd4);
    check("ovf flag",     32'(ovf0),   32'd1);
    check("ovf head sof", 32'(sof0),   32'(TAG));
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("ovf read %0d", i), 32'(data0), 32'(i));
      pop0();
    end
    check("ovf drained valid", 32'(valid0), 32'd0);
    check("ovf still sticky",  32'(ovf0),   32'd1);
    pop0();
    check("pop while empty count", 32'(count0), 32'd0);
    clr0 = 1'b1;
    wait_clks(1);
    clr0 = 1'b0;
    check("ovf cleared", 32'(ovf0), 32'd0);

    // Partial word: 5 bits then SSEL high
    m0_open();
    m0_bits(32'h1B, 5);
    wait_clks(4);
    ssel0 = 1'b1;
    fe_cycles = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (fe0) fe_cycles++;
    end
    check("frame_err pulse cycles", 32'(fe_cycles), 32'd1);
    check("frame_err count",        32'(count0),    32'd0);
    m0_open();
    m0_bits(32'h5A, 8);
    m0_close();
    check("after partial data", 32'(data0), 32'h5A);
    check("after partial sof",  32'(sof0),  32'(TAG));
    pop0();

    // Full FIFO, pop in the very cycle the fifth word is pushed
    m0_open();
    for (int i = 0; i < 4; i++) m0_bits(32'h10 + 32'(i), 8);
    check("full count", 32'(count0), 32'd4);
    m0_bits(32'h0A, 7);
    mosi0 = 1'b0;
    wait_clks(4);
    sck0 = 1'b1;
    wait_clks(2);
    rd0 = 1'b1;
    wait_clks(1);
    rd0 = 1'b0;
    wait_clks(1);
    sck0 = 1'b0;
    wait_clks(4);
    m0_close();
    check("push+pop count", 32'(count0), 32'd4);
    check("push+pop ovf",   32'(ovf0),   32'd0);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("push+pop order %0d", i), 32'(data0), 32'h10 + 32'(i));
      pop0();
    end
    check("push+pop drained", 32'(valid0), 32'd0);

    // Reset mid-word with a stored word present
    m0_open();
    m0_bits(32'h11, 8);
    m0_bits(32'hA, 4);
    check("pre-reset count", 32'(count0), 32'd1);
    rst_n = 1'b0;
    wait_clks(2);
    check("mid reset data",  32'(data0),  32'd0);
    check("mid reset valid", 32'(valid0), 32'd0);
    check("mid reset count", 32'(count0), 32'd0);
    check("mid reset ovf",   32'(ovf0),   32'd0);
    check("mid reset fe",    32'(fe0),    32'd0);
    check("mid reset sof",   32'(sof0),   32'd0);
    rst_n = 1'b1;
    wait_clks(6);
    // SSEL still low from before reset: no assertion edge, bits are ignored
    m0_bits(32'hFF, 8);
    wait_clks(4);
    check("ignored w/o ssel edge", 32'(count0), 32'd0);
    m0_close();
    m0_open();
    m0_bits(32'h77, 8);
    m0_close();
    check("post reset data",  32'(data0),  32'h77);
    check("post reset count", 32'(count0), 32'd1);
    check("post reset sof",   32'(sof0),   32'(TAG));
    pop0();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
